simon_iter_core: RTL

SIMON_ITER_CORE -- requirements
Module: simon_iter_core

---
 rtl/simon_iter_core.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/simon_iter_core.sv
// Iterative SIMON block cipher core: one round per cycle, on-chip key expansion,
// with round keys kept in a register file so they can be reused across blocks.
`timescale 1ns/1ps
module simon_iter_core #(
   parameter int          N     = 32,
   parameter int          M     = 3,
   parameter int          T     = 42,
   parameter logic [61:0] Z_SEQ = 62'b10101111011100000011010010011000101000010001111110010110110011
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [M*N-1:0]   key_in,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [2*N-1:0]   block_in,
   input  logic             decrypt,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [2*N-1:0]   block_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW = (T > 1) ? $clog2(T) : 1;
   localparam int JW = (CW < 7) ? 7 : CW;
   localparam logic [CW-1:0] LAST      = CW'(T - 1);
   localparam logic [CW-1:0] FIRST_KEY = CW'(M);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYEXP = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t         r_state;
   logic           r_key_loaded;
   logic           r_busy;
   logic           r_out_valid;
   logic           r_mode;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_x;
   logic [N-1:0]   r_y;
   logic [2*N-1:0] r_block_out;
   logic [N-1:0]   r_rk [0:T-1];

   logic [N-1:0]   w_tmp;
   logic [N-1:0]   w_rk_new;
   logic [N-1:0]   w_rk_run;
   logic [N-1:0]   w_x_nxt;
   logic [N-1:0]   w_y_nxt;
   logic [JW-1:0]  w_j;
   logic [5:0]     w_zidx;
   logic           w_zbit;

   function automatic logic [N-1:0] ror3(input logic [N-1:0] v);
      return {v[2:0], v[N-1:3]};
   endfunction

   function automatic logic [N-1:0] ror1(input logic [N-1:0] v);
      return {v[0], v[N-1:1]};
   endfunction

   function automatic logic [N-1:0] f_round(input logic [N-1:0] v);
      return ({v[N-2:0], v[N-1]} & {v[N-9:0], v[N-1:N-8]}) ^ {v[N-3:0], v[N-1:N-2]};
   endfunction

   // Next round key (KEYEXP, r_cnt = i) and next cipher state (RUN, r_cnt = r).
   always_comb begin
      w_tmp = ror3(r_rk[r_cnt - CW'(1)]);
      if (M == 4) begin
         w_tmp = w_tmp ^ r_rk[r_cnt - CW'(3)];
      end else begin
         w_tmp = w_tmp;
      end
      w_tmp    = w_tmp ^ ror1(w_tmp);
      w_j      = JW'(r_cnt) - JW'(M);
      w_zidx   = 6'(JW'(61) - (w_j % JW'(62)));
      w_zbit   = Z_SEQ[w_zidx];
      w_rk_new = ~r_rk[r_cnt - FIRST_KEY] ^ w_tmp ^ {{(N-1){1'b0}}, w_zbit}
                 ^ {{(N-2){1'b0}}, 2'b11};
      w_rk_run = r_mode ? r_rk[LAST - r_cnt] : r_rk[r_cnt];
      if (r_mode) begin
         w_x_nxt = r_y;
         w_y_nxt = r_x ^ f_round(r_y) ^ w_rk_run;
      end else begin
         w_x_nxt = r_y ^ f_round(r_x) ^ w_rk_run;
         w_y_nxt = r_x;
      end
   end

   // Round-key file: no reset, contents only meaningful once r_key_loaded is set.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && key_valid) begin
         for (int k = 0; k < M; k++) begin
            r_rk[k] <= key_in[k*N +: N];
         end
      end else if (r_state == KEYEXP) begin
         r_rk[r_cnt] <= w_rk_new;
      end
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_key_loaded <= 1'b0;
         r_busy       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_mode       <= 1'b0;
         r_cnt        <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_block_out  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (key_valid) begin
                  r_state      <= KEYEXP;
                  r_key_loaded <= 1'b0;
                  r_busy       <= 1'b1;
                  r_cnt        <= FIRST_KEY;
               end else if (r_key_loaded && in_valid) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_x     <= block_in[2*N-1:N];
                  r_y     <= block_in[N-1:0];
                  r_mode  <= decrypt;
                  r_cnt   <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
            KEYEXP: begin
               if (r_cnt == LAST) begin
                  r_state      <= IDLE;
                  r_key_loaded <= 1'b1;
                  r_busy       <= 1'b0;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RUN: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               if (r_cnt == LAST) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_block_out <= {w_x_nxt, w_y_nxt};
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end else begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
               r_cnt       <= '0;
            end
         endcase
      end
   end

   // A key presented alongside a block takes priority, so the block is refused.
   assign key_ready = ~r_busy;
   assign in_ready  = ~r_busy & r_key_loaded & ~key_valid;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign block_out = r_block_out;

endmodule
